// File: rtl/regfile_pkg.sv
// Shared constants and the write-request type for the register file write-back path.
package regfile_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_REGS   = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [XLEN-1:0]       data;
    } wb_req_t;

endpackage

// File: rtl/regfile_writeback_if.sv
// Producer, decode and register-file signals of the write-back front end.
interface regfile_writeback_if;
    import regfile_pkg::*;

    logic                  aluValid;
    logic                  aluReady;
    logic [REG_ADDR_W-1:0] aluAddr;
    logic [XLEN-1:0]       aluData;
    logic                  memValid;
    logic [REG_ADDR_W-1:0] memAddr;
    logic [XLEN-1:0]       memData;
    logic                  issueValid;
    logic [REG_ADDR_W-1:0] issueAddr;
    logic                  regWrite;
    logic [REG_ADDR_W-1:0] writeAddr;
    logic [XLEN-1:0]       writeData;
    logic [NUM_REGS-1:0]   pendingMask;

    modport master (
        output aluValid, aluAddr, aluData, memValid, memAddr, memData, issueValid, issueAddr,
        input  aluReady, regWrite, writeAddr, writeData, pendingMask
    );

    modport slave (
        input  aluValid, aluAddr, aluData, memValid, memAddr, memData, issueValid, issueAddr,
        output aluReady, regWrite, writeAddr, writeData, pendingMask
    );

endinterface

// File: rtl/wb_fifo.sv
// Synchronous FIFO of write-back requests; full/empty come from the registered count.
module wb_fifo
    import regfile_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  wb_req_t          din,
    output wb_req_t          dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    wb_req_t          mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    // Self-protecting: overflow and underflow requests are ignored.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= din;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/regfile_writeback.sv
// Single write-port front end: loads win the port, ALU results queue, pending-write scoreboard.
module regfile_writeback
    import regfile_pkg::*;
#(
    parameter int unsigned ALU_FIFO_DEPTH = 4
) (
    input logic                clock,
    input logic                reset,
    regfile_writeback_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(ALU_FIFO_DEPTH) + 1;

    wb_req_t             alu_req;
    wb_req_t             mem_req;
    wb_req_t             fifo_dout;
    wb_req_t             sel_req;
    logic                sel_valid;
    logic                commit_en;
    logic                fifo_full;
    logic                fifo_empty;
    logic [CNT_W-1:0]    fifo_count;
    logic                fifo_push;
    logic                fifo_pop;
    logic                alu_ready;

    logic                  reg_write_q;
    logic [REG_ADDR_W-1:0] write_addr_q;
    logic [XLEN-1:0]       write_data_q;
    logic [NUM_REGS-1:0]   pending_q;
    logic [NUM_REGS-1:0]   pending_d;

    assign alu_req = '{addr: bus.aluAddr, data: bus.aluData};
    assign mem_req = '{addr: bus.memAddr, data: bus.memData};

    // Ready is purely registered: a full FIFO stays unready even in a cycle it pops.
    assign alu_ready = !fifo_full;
    assign fifo_push = bus.aluValid && alu_ready;
    assign fifo_pop  = !bus.memValid && !fifo_empty;

    wb_fifo #(
        .DEPTH(ALU_FIFO_DEPTH)
    ) u_alu_fifo (
        .clock(clock),
        .reset(reset),
        .push (fifo_push),
        .pop  (fifo_pop),
        .din  (alu_req),
        .dout (fifo_dout),
        .full (fifo_full),
        .empty(fifo_empty),
        .count(fifo_count)
    );

    always_comb begin
        assert (fifo_empty == (fifo_count == '0));
    end

    // Load returns cannot stall, so they always take the port.
    always_comb begin
        sel_valid = 1'b0;
        sel_req   = '0;
        if (bus.memValid) begin
            sel_valid = 1'b1;
            sel_req   = mem_req;
        end else if (!fifo_empty) begin
            sel_valid = 1'b1;
            sel_req   = fifo_dout;
        end
    end

    assign commit_en = sel_valid && (sel_req.addr != '0);

    always_comb begin
        pending_d = pending_q;
        if (commit_en) begin
            pending_d[sel_req.addr] = 1'b0;
        end
        // A same-edge issue belongs to a newer instruction, so it overrides the clear.
        if (bus.issueValid && (bus.issueAddr != '0)) begin
            pending_d[bus.issueAddr] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            reg_write_q  <= 1'b0;
            write_addr_q <= '0;
            write_data_q <= '0;
            pending_q    <= '0;
        end else begin
            reg_write_q <= commit_en;
            if (sel_valid) begin
                write_addr_q <= sel_req.addr;
                write_data_q <= sel_req.data;
            end
            pending_q <= pending_d;
        end
    end

    assign bus.aluReady    = alu_ready;
    assign bus.regWrite    = reg_write_q;
    assign bus.writeAddr   = write_addr_q;
    assign bus.writeData   = write_data_q;
    assign bus.pendingMask = pending_q;

endmodule

// File: doc/regfile_writeback.md
Name: regfile_writeback

Overview:
- Single write-port front end for the 32x32 register file.
- Merges two producers, the ALU result path and the load/memory return path, onto the register file's regWrite/writeAddr/writeData port.
- Buffers ALU results in a small FIFO so that load returns, which cannot be stalled, always win the port.
- Keeps a pending-write scoreboard so decode can stall on registers with an in-flight write.

Parameters:
- XLEN, 32, data width of a register write.
- REG_ADDR_W, 5, register address width (32 registers).
- ALU_FIFO_DEPTH, 4, ALU result buffer entries; power of two, at least 2.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- aluValid  input  1  ALU offers a result this cycle.
- aluReady  output  1  FIFO can accept; equals !full, from registered count only.
- aluAddr  input  REG_ADDR_W  ALU destination register.
- aluData  input  XLEN  ALU result.
- memValid  input  1  load data returns this cycle; always accepted (no ready).
- memAddr  input  REG_ADDR_W  load destination register.
- memData  input  XLEN  load data.
- issueValid  input  1  decode issues an instruction with a destination register.
- issueAddr  input  REG_ADDR_W  destination of the issued instruction.
- regWrite  output  1  to register file write enable.
- writeAddr  output  REG_ADDR_W  to register file write address.
- writeData  output  XLEN  to register file write data.
- pendingMask  output  32  bit i set means register i has an outstanding write.

Behaviour:
- Reset:
  - Outputs: regWrite=0, writeAddr=0, writeData=0, pendingMask=0, aluReady=1.
  - FIFO is empty; pointers and count are 0.
  - Asserting reset mid-operation discards FIFO contents and the pending commit immediately.
- ALU FIFO:
  - Push when aluValid && aluReady.
  - Full with a simultaneous pop: aluReady stays 0 that cycle; no same-cycle ready recovery.
  - Read and write pointers wrap modulo ALU_FIFO_DEPTH.
  - Count has width clog2(DEPTH)+1.
- Arbitration, evaluated each cycle:
  - memValid=1: the memory request is selected. The FIFO does not pop.
  - memValid=0 and FIFO not empty: the FIFO head is selected and popped.
  - Otherwise nothing is selected.
  - A push and a pop in the same cycle leave the count unchanged.
- Commit register:
  - At the edge ending a cycle with a selection, writeAddr and writeData take the selected entry.
  - At the same edge, regWrite takes 1 if the address is nonzero, else 0.
  - With no selection, regWrite becomes 0 and writeAddr/writeData hold their values.
- Latency:
  - memValid in cycle k gives regWrite in cycle k+1.
  - ALU push in cycle k into an empty FIFO, with memValid=0 in cycle k+1, gives regWrite in cycle k+2.
  - Each cycle of memValid delays the FIFO drain by one cycle.
- x0 handling:
  - Writes with address 0 are consumed (popped or accepted) but never assert regWrite.
  - pendingMask[0] is constantly 0.
- Scoreboard:
  - Set: the bit for issueAddr is set at the edge if issueValid && issueAddr!=0.
  - Clear: the bit for the committed address is cleared at the same edge that raises regWrite for that address.
  - Set and clear of the same bit at the same edge: set wins, since a newer instruction now owns the register.
  - Multiple outstanding writes to one register are not counted; decode must stall issue of a register whose bit is already set.
- Ordering:
  - ALU results commit in FIFO order.
  - No ordering is enforced between the ALU and memory paths; the scoreboard prevents write-after-write hazards.

Decomposition:
- Package regfile_pkg:
  - XLEN and REG_ADDR_W constants.
  - NUM_REGS = 32.
  - typedef wb_req_t, a packed struct of addr [REG_ADDR_W-1:0] and data [XLEN-1:0].
- One sub-module, wb_fifo: synchronous FIFO of wb_req_t.
  - Parameter DEPTH.
  - Ports push, pop, din, dout, full, empty, count.
  - Async active-high reset.
- Arbitration, commit register and scoreboard stay in regfile_writeback.

Test Plan:
- Reset mid-operation: push 3 ALU entries, assert reset for 1 cycle -> regWrite=0 and pendingMask=0 immediately; aluReady=1 after reset; no stale write ever appears.
- Single ALU path: issue addr 5; push aluAddr=5, aluData=0xDEADBEEF with the FIFO empty -> regWrite=1, writeAddr=5, writeData=0xDEADBEEF exactly 2 cycles after the push; pendingMask[5] clears at that edge.
- Memory priority: FIFO holds addr 3 (0x11); memValid with addr 7 (0x22) for 2 consecutive cycles -> commits are 7/0x22, 7/0x22, then 3/0x11.
- Full FIFO: push 4 entries with memValid held high -> aluReady=0 on the 5th cycle; release memValid -> entries drain in order at one per cycle, and aluReady=1 after the first pop.
- x0 write: push aluAddr=0, aluData=0xFFFFFFFF -> the entry is popped, regWrite stays 0 and pendingMask is unchanged.
- Scoreboard race: pendingMask[9] set; in the cycle the write to addr 9 is selected, issueValid with issueAddr=9 -> pendingMask[9] remains 1 after the edge.
